serial_adder: RTL and testbench

Bit-serial, LSB-first ripple adder: captures two WIDTH-bit operands and a carry-in on a start handshake, then forms the sum one bit per clock through a single one-bit full-adder cell and a carry flip-flop. It is the additive counterpart of the team's one-bit full-subtractor cell. It sits alongside that cell in the arithmetic library as the area-minimal adder for datapaths that can afford WIDTH+1 cycles of latency.

---
 rtl/arith_pkg.sv | 12 +
 rtl/full_add.sv | 13 +
 rtl/serial_adder.sv | 88 ++++++++
 tb/tb_serial_adder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: serial FSM state encoding and default widths.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SERIAL_ADDER_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_add.sv
// Combinational one-bit full adder; additive sibling of the full-subtractor cell.
module full_add (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-add cell plus a carry flip-flop, WIDTH steps per operation.
module serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADDER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             s_bit
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state;
    state_t          next_state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic            carry;
    logic [CW-1:0]   count;
    logic            fa_s;
    logic            fa_cout;

    full_add u_full_add (
        .a    (ra[0]),
        .b    (rb[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (count == LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // sum/cout are deliberately left alone on start so the previous result stays visible until RUN overwrites it
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        carry <= cin;
                        count <= '0;
                    end
                end
                RUN: begin
                    sum   <= {fa_s, sum[WIDTH-1:1]};
                    ra    <= ra >> 1;
                    rb    <= rb >> 1;
                    carry <= fa_cout;
                    count <= count + CW'(1);
                    if (count == LAST) cout <= fa_cout;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    assign s_bit = busy & fa_s;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=2.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, cin8, busy8, done8, cout8, sbit8;
    logic [7:0] a8, b8, sum8;
    logic       start2, cin2, busy2, done2, cout2, sbit2;
    logic [1:0] a2, b2, sum2;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .s_bit(sbit8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .s_bit(sbit2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 operation; operands are scrambled right after capture
    task automatic do_op8(input logic [7:0] x, input logic [7:0] y, input logic c,
                          output int nbusy, output int ndone, output int done_at,
                          output logic [7:0] s, output logic co, output logic [7:0] sb,
                          output int overlap);
        nbusy = 0; ndone = 0; done_at = -1; s = '0; co = 1'b0; sb = '0; overlap = 0;
        a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
        step();
        start8 = 1'b0; a8 = ~x; b8 = ~y; cin8 = ~c;
        for (int j = 0; j < 12; j++) begin
            if (busy8 && done8) overlap++;
            if (busy8) begin
                if (nbusy < 8) sb[nbusy] = sbit8;
                nbusy++;
            end
            if (done8) begin
                if (ndone == 0) begin
                    done_at = j; s = sum8; co = cout8;
                end
                ndone++;
            end
            step();
        end
    endtask

    task automatic do_op2(input logic [1:0] x, input logic [1:0] y, input logic c,
                          output int ndone, output int done_at,
                          output logic [1:0] s, output logic co);
        ndone = 0; done_at = -1; s = '0; co = 1'b0;
        a2 = x; b2 = y; cin2 = c; start2 = 1'b1;
        step();
        start2 = 1'b0; a2 = ~x; b2 = ~y; cin2 = ~c;
        for (int j = 0; j < 6; j++) begin
            if (done2) begin
                if (ndone == 0) begin
                    done_at = j; s = sum2; co = cout2;
                end
                ndone++;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++;
        if ({busy8, done8, sum8, cout8, sbit8} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_outputs8: got %h expected 000", {busy8, done8, sum8, cout8, sbit8});
        end
        checks++;
        if ({busy2, done2, sum2, cout2, sbit2} !== 6'h00) begin
            errors++;
            $display("[TB] FAIL reset_outputs2: got %h expected 00", {busy2, done2, sum2, cout2, sbit2});
        end
        rst = 1'b0;
        step();
        checks++;
        if ({busy8, done8} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: busy/done %b expected 00", {busy8, done8});
        end
    endtask

    task automatic test_basic();
        int nb, nd, da, ov;
        logic [7:0] s, sb;
        logic co;
        do_op8(8'h0F, 8'h01, 1'b0, nb, nd, da, s, co, sb, ov);
        checks++;
        if (da !== 8) begin errors++; $display("[TB] FAIL basic_done_at: got %0d expected 8", da); end
        checks++;
        if (nd !== 1) begin errors++; $display("[TB] FAIL basic_done_count: got %0d expected 1", nd); end
        checks++;
        if (nb !== 8) begin errors++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 8", nb); end
        checks++;
        if ({co, s} !== 9'h010) begin errors++; $display("[TB] FAIL basic_sum: got %h expected 010", {co, s}); end
        checks++;
        if (sb !== 8'h10) begin errors++; $display("[TB] FAIL basic_s_bit: got %h expected 10", sb); end
        checks++;
        if (ov !== 0) begin errors++; $display("[TB] FAIL basic_busy_done_overlap: got %0d expected 0", ov); end
        checks++;
        if ({co, s} !== {cout8, sum8}) begin
            errors++;
            $display("[TB] FAIL basic_hold: got %h expected %h", {cout8, sum8}, {co, s});
        end
    endtask

    task automatic test_overflow();
        int nb, nd, da, ov;
        logic [7:0] s, sb;
        logic co;
        do_op8(8'hFF, 8'h01, 1'b0, nb, nd, da, s, co, sb, ov);
        checks++;
        if (nd !== 1 || {co, s} !== 9'h100) begin
            errors++;
            $display("[TB] FAIL overflow_ff_01: got done=%0d %h expected done=1 100", nd, {co, s});
        end
        do_op8(8'hFF, 8'hFF, 1'b1, nb, nd, da, s, co, sb, ov);
        checks++;
        if (nd !== 1 || {co, s} !== 9'h1FF) begin
            errors++;
            $display("[TB] FAIL overflow_ff_ff_1: got done=%0d %h expected done=1 1ff", nd, {co, s});
        end
        checks++;
        if (sb !== 8'hFF) begin errors++; $display("[TB] FAIL overflow_s_bit: got %h expected ff", sb); end
    endtask

    task automatic test_ignored_inputs();
        int nd;
        logic [8:0] res;
        nd = 0; res = '0;
        a8 = 8'h5A; b8 = 8'h23; cin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int j = 0; j < 12; j++) begin
            if (j == 2) begin
                start8 = 1'b1; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            if (done8) begin
                if (nd == 0) res = {cout8, sum8};
                nd++;
            end
            step();
        end
        checks++;
        if (nd !== 1) begin errors++; $display("[TB] FAIL ignored_done_count: got %0d expected 1", nd); end
        checks++;
        if (res !== 9'h07D) begin errors++; $display("[TB] FAIL ignored_result: got %h expected 07d", res); end
        checks++;
        if ({cout8, sum8} !== 9'h07D) begin
            errors++;
            $display("[TB] FAIL ignored_hold: got %h expected 07d", {cout8, sum8});
        end
    endtask

    task automatic test_reset_mid_run();
        int nb, nd, da, ov;
        logic [7:0] s, sb;
        logic co;
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({busy8, done8, sum8, cout8, sbit8} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL midrun_reset_outputs: got %h expected 000", {busy8, done8, sum8, cout8, sbit8});
        end
        nd = 0;
        for (int j = 0; j < 12; j++) begin
            if (done8 || busy8) nd++;
            step();
        end
        checks++;
        if (nd !== 0) begin errors++; $display("[TB] FAIL midrun_no_done: got %0d active cycles expected 0", nd); end
        do_op8(8'h12, 8'h34, 1'b0, nb, nd, da, s, co, sb, ov);
        checks++;
        if (nd !== 1 || da !== 8 || {co, s} !== 9'h046) begin
            errors++;
            $display("[TB] FAIL after_reset_add: got done=%0d at %0d %h expected done=1 at 8 046", nd, da, {co, s});
        end
    endtask

    task automatic test_back_to_back();
        int nd, last;
        nd = 0; last = -1;
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
        step();
        for (int j = 0; j < 35; j++) begin
            if (done8) begin
                checks++;
                if ((nd == 0 && j !== 8) || (nd > 0 && j - last !== 10)) begin
                    errors++;
                    $display("[TB] FAIL b2b_spacing: done at %0d previous %0d expected first 8 then every 10", j, last);
                end
                checks++;
                if ({cout8, sum8} !== 9'h100) begin
                    errors++;
                    $display("[TB] FAIL b2b_sum: got %h expected 100", {cout8, sum8});
                end
                last = j;
                nd++;
            end
            step();
        end
        start8 = 1'b0;
        checks++;
        if (nd !== 3) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 3", nd); end
        for (int j = 0; j < 12; j++) step();
    endtask

    task automatic test_random8();
        int nb, nd, da, ov;
        logic [7:0] s, sb, x, y;
        logic co, c;
        logic [8:0] exp_v;
        for (int i = 0; i < 200; i++) begin
            x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
            exp_v = {1'b0, x} + {1'b0, y} + {8'h00, c};
            do_op8(x, y, c, nb, nd, da, s, co, sb, ov);
            checks++;
            if (nd !== 1 || {co, s} !== exp_v) begin
                errors++;
                $display("[TB] FAIL rand8 %h+%h+%b: got done=%0d %h expected done=1 %h", x, y, c, nd, {co, s}, exp_v);
            end
        end
    endtask

    task automatic test_width2();
        int nd, da;
        logic [1:0] s, x, y;
        logic co, c;
        logic [2:0] exp_v;
        do_op2(2'd3, 2'd3, 1'b1, nd, da, s, co);
        checks++;
        if (nd !== 1 || da !== 2 || {co, s} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL w2_3_3_1: got done=%0d at %0d %b expected done=1 at 2 111", nd, da, {co, s});
        end
        for (int i = 0; i < 200; i++) begin
            x = 2'($urandom); y = 2'($urandom); c = 1'($urandom);
            exp_v = {1'b0, x} + {1'b0, y} + {2'b00, c};
            do_op2(x, y, c, nd, da, s, co);
            checks++;
            if (nd !== 1 || {co, s} !== exp_v) begin
                errors++;
                $display("[TB] FAIL rand2 %0d+%0d+%b: got done=%0d %b expected done=1 %b", x, y, c, nd, {co, s}, exp_v);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        step();
        test_reset();
        test_basic();
        test_overflow();
        test_ignored_inputs();
        test_reset_mid_run();
        test_back_to_back();
        test_random8();
        test_width2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
